// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction (I) and data (D) ports share one physical port.
// Define MEM_ARB_FAIR_EN to add a starvation counter that forces an I grant after STARVE_LIMIT D grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_mem_read,
  input  logic [15:0] i_mem_address,
  output logic [15:0] i_mem_rdata,
  output logic        i_mem_resp,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [15:0] d_mem_address,
  input  logic [15:0] d_mem_wdata,
  input  logic [1:0]  d_mem_byte_enable,
  output logic [15:0] d_mem_rdata,
  output logic        d_mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t      state_q, state_d;
  logic [15:0] txnAddr_q, txnAddr_d;
  logic [15:0] txnWdata_q, txnWdata_d;
  logic [1:0]  txnBe_q, txnBe_d;
  logic        txnWrite_q, txnWrite_d;
  logic        dReq, starved, grantI, grantD;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : gBadStarveLimit
    $error("STARVE_LIMIT must fit the 3-bit starve counter (1..7)");
  end

  assign dReq = d_mem_read | d_mem_write;

`ifdef MEM_ARB_FAIR_EN
  logic [2:0] starveCnt_q, starveCnt_d;

  assign starved = i_mem_read && (starveCnt_q == 3'(STARVE_LIMIT));

  // Counts D grants made while I was waiting; any I grant or idle I port clears it.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (state_q == IDLE) begin
      if (!i_mem_read || grantI) starveCnt_d = 3'd0;
      else if (grantD && starveCnt_q != 3'd7) starveCnt_d = starveCnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starveCnt_q <= 3'd0;
    else          starveCnt_q <= starveCnt_d;
  end
`else
  assign starved = 1'b0;
`endif

  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (state_q == IDLE) begin
      if (starved)         grantI = 1'b1;
      else if (dReq)       grantD = 1'b1;
      else if (i_mem_read) grantI = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:           if (grantD) state_d = D_BUSY;
                      else if (grantI) state_d = I_BUSY;
      I_BUSY, D_BUSY: if (pmem_resp) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Transaction register is loaded only on the grant edge so later request changes cannot leak out.
  always_comb begin
    txnAddr_d  = txnAddr_q;
    txnWdata_d = txnWdata_q;
    txnBe_d    = txnBe_q;
    txnWrite_d = txnWrite_q;
    if (grantD) begin
      txnAddr_d  = d_mem_address;
      txnWdata_d = d_mem_wdata;
      txnBe_d    = d_mem_byte_enable;
      txnWrite_d = d_mem_write;
    end else if (grantI) begin
      txnAddr_d  = i_mem_address;
      txnWdata_d = 16'h0000;
      txnBe_d    = 2'b11;
      txnWrite_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      txnAddr_q  <= 16'h0000;
      txnWdata_q <= 16'h0000;
      txnBe_q    <= 2'b00;
      txnWrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txnAddr_q  <= txnAddr_d;
      txnWdata_q <= txnWdata_d;
      txnBe_q    <= txnBe_d;
      txnWrite_q <= txnWrite_d;
    end
  end

  always_comb begin
    pmem_read        = (state_q != IDLE) && !txnWrite_q;
    pmem_write       = (state_q != IDLE) && txnWrite_q;
    pmem_address     = txnAddr_q;
    pmem_wdata       = txnWdata_q;
    pmem_byte_enable = txnBe_q;
    i_mem_resp       = (state_q == I_BUSY) && pmem_resp;
    d_mem_resp       = (state_q == D_BUSY) && pmem_resp;
  end

  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset/fairness sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_mem_read;
  logic [15:0] i_mem_address;
  logic [15:0] i_mem_rdata;
  logic        i_mem_resp;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [15:0] d_mem_address;
  logic [15:0] d_mem_wdata;
  logic [1:0]  d_mem_byte_enable;
  logic [15:0] d_mem_rdata;
  logic        d_mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  int errCount = 0;
  int checkCount = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_byte_enable(d_mem_byte_enable),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iRead; logic [15:0] iAddr;
    logic dRead; logic dWrite; logic [15:0] dAddr; logic [15:0] dWdata; logic [1:0] dBe;
    logic pResp; logic [15:0] pRdata;
    logic eRead; logic eWrite;
    logic chkBus; logic [15:0] eAddr; logic [1:0] eBe;
    logic chkWd; logic [15:0] eWdata;
    logic eIResp; logic eDResp;
  } vec_t;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_mem_read        = v.iRead;
    i_mem_address     = v.iAddr;
    d_mem_read        = v.dRead;
    d_mem_write       = v.dWrite;
    d_mem_address     = v.dAddr;
    d_mem_wdata       = v.dWdata;
    d_mem_byte_enable = v.dBe;
    pmem_resp         = v.pResp;
    pmem_rdata        = v.pRdata;
  endtask

  task automatic clearInputs();
    i_mem_read = 0; i_mem_address = 0;
    d_mem_read = 0; d_mem_write = 0; d_mem_address = 0; d_mem_wdata = 0; d_mem_byte_enable = 0;
    pmem_resp = 0; pmem_rdata = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[17];
  int   grantsSeen[$];
  // Reference model state: one outstanding transaction at most
  bit          mBusy, mIsD, mWrite;
  logic [15:0] mAddr, mWdata;
  logic [1:0]  mBe;
  int          mStarve;

  initial begin
    vecs[0]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0};
    vecs[1]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h1111, 1, 0, 1, 16'h0010, 2'b11, 0, 16'h0000, 0, 0};
    vecs[2]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h2222, 1, 0, 1, 16'h0010, 2'b11, 0, 16'h0000, 0, 0};
    vecs[3]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'hBEEF, 1, 0, 1, 16'h0010, 2'b11, 0, 16'h0000, 1, 0};
    vecs[4]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0};
    vecs[5]  = '{1, 16'h0042, 0, 1, 16'h2000, 16'h1234, 2'b01, 0, 16'h0000, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0};
    vecs[6]  = '{1, 16'h0042, 0, 1, 16'h3000, 16'h9999, 2'b10, 0, 16'h0000, 0, 1, 1, 16'h2000, 2'b01, 1, 16'h1234, 0, 0};
    vecs[7]  = '{1, 16'h0042, 0, 0, 16'h3000, 16'h9999, 2'b10, 1, 16'h5555, 0, 1, 1, 16'h2000, 2'b01, 1, 16'h1234, 0, 1};
    vecs[8]  = '{1, 16'h0042, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0};
    vecs[9]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 1, 16'h0042, 2'b11, 0, 16'h0000, 0, 0};
    vecs[10] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h7E57, 1, 0, 1, 16'h0042, 2'b11, 0, 16'h0000, 1, 0};
    vecs[11] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'hABCD, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0};
    vecs[12] = '{0, 16'h0000, 1, 1, 16'h4444, 16'hAAAA, 2'b10, 0, 16'h0000, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0};
    vecs[13] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h1357, 0, 1, 1, 16'h4444, 2'b10, 1, 16'hAAAA, 0, 1};
    vecs[14] = '{0, 16'h0000, 1, 0, 16'h5000, 16'h0000, 2'b11, 0, 16'h0000, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0};
    vecs[15] = '{0, 16'h0000, 1, 0, 16'h5000, 16'h0000, 2'b11, 1, 16'h2468, 1, 0, 1, 16'h5000, 2'b11, 0, 16'h0000, 0, 1};
    vecs[16] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0};

    // Reset state, with a stray pmem_resp that must not be forwarded
    clearInputs();
    reset_n = 1'b0;
    pmem_resp = 1'b1;
    #3;
    checkOutput("reset_pmem_read", pmem_read, 0);
    checkOutput("reset_pmem_write", pmem_write, 0);
    checkOutput("reset_i_resp", i_mem_resp, 0);
    checkOutput("reset_d_resp", d_mem_resp, 0);
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("vec%0d_pmem_read", k), pmem_read, vecs[k].eRead);
      checkOutput($sformatf("vec%0d_pmem_write", k), pmem_write, vecs[k].eWrite);
      checkOutput($sformatf("vec%0d_i_resp", k), i_mem_resp, vecs[k].eIResp);
      checkOutput($sformatf("vec%0d_d_resp", k), d_mem_resp, vecs[k].eDResp);
      checkOutput($sformatf("vec%0d_i_rdata", k), i_mem_rdata, vecs[k].pRdata);
      checkOutput($sformatf("vec%0d_d_rdata", k), d_mem_rdata, vecs[k].pRdata);
      if (vecs[k].chkBus) begin
        checkOutput($sformatf("vec%0d_addr", k), pmem_address, vecs[k].eAddr);
        checkOutput($sformatf("vec%0d_be", k), pmem_byte_enable, vecs[k].eBe);
      end
      if (vecs[k].chkWd)
        checkOutput($sformatf("vec%0d_wdata", k), pmem_wdata, vecs[k].eWdata);
    end

    // Reset pulsed in the middle of an I transaction, then a late response
    doReset();
    i_mem_read = 1'b1;
    i_mem_address = 16'h0077;
    @(negedge clk);
    #1;
    checkOutput("rst_mid_busy_read", pmem_read, 1);
    checkOutput("rst_mid_busy_addr", pmem_address, 16'h0077);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_async_read", pmem_read, 0);
    i_mem_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pmem_resp = 1'b1;
    #1;
    checkOutput("rst_late_resp_i", i_mem_resp, 0);
    checkOutput("rst_late_resp_read", pmem_read, 0);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    checkOutput("rst_after_idle_read", pmem_read, 0);

    // Both requesters saturated, single-cycle memory: record grant order
    doReset();
    i_mem_read = 1'b1; i_mem_address = 16'h0100;
    d_mem_read = 1'b1; d_mem_address = 16'h0200; d_mem_byte_enable = 2'b11;
    pmem_resp = 1'b1;
    grantsSeen.delete();
    for (int c = 0; c < 40 && grantsSeen.size() < 10; c++) begin
      @(negedge clk);
      #1;
      if (d_mem_resp) grantsSeen.push_back(1);
      else if (i_mem_resp) grantsSeen.push_back(2);
    end
    checkOutput("fair_grant_count", 16'(grantsSeen.size()), 16'd10);
    for (int k = 0; k < grantsSeen.size(); k++) begin
      int expOwner;
`ifdef MEM_ARB_FAIR_EN
      expOwner = ((k % (LIMIT + 1)) == LIMIT) ? 2 : 1;
`else
      expOwner = 1;
`endif
      checkOutput($sformatf("grant%0d_owner", k), 16'(grantsSeen[k]), 16'(expOwner));
    end

    // Randomized traffic against the transaction-level model
    doReset();
    mBusy = 0; mIsD = 0; mWrite = 0; mAddr = 0; mWdata = 0; mBe = 0; mStarve = 0;
    for (int c = 0; c < 400; c++) begin
      bit takeI, takeD, starvedNow;
      int dSel;
      @(negedge clk);
      i_mem_read = ($urandom_range(3) != 0);
      i_mem_address = 16'($urandom);
      dSel = $urandom_range(5);
      d_mem_read = (dSel == 1) || (dSel == 3);
      d_mem_write = (dSel == 2) || (dSel == 3);
      d_mem_address = 16'($urandom);
      d_mem_wdata = 16'($urandom);
      d_mem_byte_enable = 2'($urandom);
      pmem_resp = ($urandom_range(2) == 0);
      pmem_rdata = 16'($urandom);
      #1;
      checkOutput("rnd_pmem_read", pmem_read, mBusy && !mWrite);
      checkOutput("rnd_pmem_write", pmem_write, mBusy && mWrite);
      checkOutput("rnd_i_resp", i_mem_resp, mBusy && !mIsD && pmem_resp);
      checkOutput("rnd_d_resp", d_mem_resp, mBusy && mIsD && pmem_resp);
      checkOutput("rnd_i_rdata", i_mem_rdata, pmem_rdata);
      if (mBusy) begin
        checkOutput("rnd_addr", pmem_address, mAddr);
        checkOutput("rnd_be", pmem_byte_enable, mBe);
        if (mIsD) checkOutput("rnd_wdata", pmem_wdata, mWdata);
      end
      if (mBusy) begin
        if (pmem_resp) mBusy = 0;
      end else begin
        starvedNow = 0;
`ifdef MEM_ARB_FAIR_EN
        starvedNow = i_mem_read && (mStarve == LIMIT);
`endif
        takeD = !starvedNow && (d_mem_read || d_mem_write);
        takeI = starvedNow || (!(d_mem_read || d_mem_write) && i_mem_read);
        if (takeD) begin
          mAddr = d_mem_address; mWdata = d_mem_wdata; mBe = d_mem_byte_enable; mWrite = d_mem_write;
        end else if (takeI) begin
          mAddr = i_mem_address; mBe = 2'b11; mWrite = 0;
        end
        if (!i_mem_read || takeI) mStarve = 0;
        else if (takeD) mStarve++;
        mBusy = takeD || takeI;
        mIsD = takeD;
      end
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive D grants while I waits (used only under MEM_ARB_FAIR_EN).
REQ-002 SHALL have ports: clk in 1, rising-edge clock; reset_n in 1, reset, asynchronous, active-low.
REQ-003 SHALL have I-port: i_mem_read in 1; i_mem_address in 16; i_mem_rdata out 16; i_mem_resp out 1.
REQ-004 SHALL have D-port: d_mem_read in 1; d_mem_write in 1; d_mem_address in 16; d_mem_wdata in 16; d_mem_byte_enable in 2; d_mem_rdata out 16; d_mem_resp out 1.
REQ-005 SHALL have physical port: pmem_read out 1; pmem_write out 1; pmem_address out 16; pmem_wdata out 16; pmem_byte_enable out 2; pmem_rdata in 16; pmem_resp in 1.

Function
REQ-006 SHALL implement FSM states IDLE, I_BUSY, D_BUSY; state register only.
REQ-007 IDLE: d request (d_mem_read|d_mem_write) -> D_BUSY; else i_mem_read -> I_BUSY; else stay.
REQ-008 On the grant edge SHALL latch address, wdata, byte_enable and op (write wins if d_mem_read and d_mem_write both high) into a transaction register.
REQ-009 In I_BUSY/D_BUSY SHALL drive pmem_* from the transaction register only; pmem_read/pmem_write low in IDLE.
REQ-010 I transactions SHALL drive pmem_byte_enable=2'b11, pmem_write=0.
REQ-011 i_mem_resp = (state==I_BUSY) & pmem_resp; d_mem_resp = (state==D_BUSY) & pmem_resp; both combinational.
REQ-012 i_mem_rdata and d_mem_rdata SHALL pass pmem_rdata combinationally, regardless of state.
REQ-013 On pmem_resp in a BUSY state SHALL return to IDLE next edge; exactly one IDLE cycle between transactions, so a requester still holding its request on the resp edge is never double-granted.
REQ-014 If the granted requester drops its request mid-transaction, SHALL hold pmem_* until pmem_resp, then return to IDLE; the resp is still forwarded for that cycle.
REQ-015 Requests changing during BUSY SHALL NOT affect pmem_* outputs.
REQ-016 Minimum latency request->pmem asserted: 1 cycle; request->resp: 1 + memory latency.

Reset
REQ-017 reset_n low SHALL immediately force state=IDLE, transaction register=0, starve counter=0; pmem_read=pmem_write=0, i_mem_resp=d_mem_resp=0.
REQ-018 Reset mid-transaction SHALL abandon it; a pmem_resp arriving after reset deassertion while in IDLE SHALL be ignored.

Configuration
REQ-019 Macro MEM_ARB_FAIR_EN defined: 3-bit starve counter increments on each D grant while i_mem_read high, clears on any I grant or when i_mem_read low in IDLE; when counter==STARVE_LIMIT and i_mem_read high, IDLE SHALL grant I even if D requests.
REQ-020 Macro MEM_ARB_FAIR_EN undefined: strict D-over-I priority, no counter logic present.

Verification
REQ-021 Reset, i_mem_read=1 addr 0x0010, pmem_resp after 3 cycles with rdata 0xBEEF -> pmem_read high cycles 1-3 addr 0x0010 be 2'b11, i_mem_resp=1 rdata 0xBEEF in cycle 3, IDLE cycle 4.
REQ-022 i_mem_read and d_mem_write (addr 0x2000, wdata 0x1234, be 2'b01) same cycle -> D granted first, pmem_write with those values; I granted after one IDLE cycle.
REQ-023 D request changes addr 0x2000->0x3000 during D_BUSY -> pmem_address stays 0x2000 until resp.
REQ-024 reset_n pulsed low during I_BUSY -> pmem_read drops asynchronously; late pmem_resp produces no i_mem_resp.
REQ-025 MEM_ARB_FAIR_EN, STARVE_LIMIT=4, D and I requesting continuously -> grant order D,D,D,D,I,D,...; without macro -> I never granted while D requests.
